nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Top-level controller for the speech-recognition network. Accepts one feature frame from the front end and starts each dense layer in turn with a pulse. Waits for each layer's done before starting the next.
- After the last layer it waits a fixed latency for the registered argmax stage (final_layer), then presents the 2-bit class through a valid/ready result handshake.
- Detects hung layers with a per-layer timeout.

Parameters:
- NUM_LAYERS, 4, number of sequenced dense layers (layer 0 runs first).
- FINAL_LAT, 2, cycles from the last layer_done until class_in is valid.
- TIMEOUT_CYCLES, 65535, maximum cycles a layer may run before a timeout error.
- CNT_W, 16, width of the timeout and latency counters; TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- feat_valid  in  1  a feature frame is ready in the layer-0 input buffer.
- feat_ready  out  1  sequencer is idle and can accept a frame.
- layer_start  out  NUM_LAYERS  one-cycle start pulse; bit i starts layer i.
- layer_done  in  NUM_LAYERS  done pulse from layer i.
- class_in  in  2  argmax output of final_layer.
- result_valid  out  1  result_class holds a valid classification.
- result_ready  in  1  consumer accepts the result.
- result_class  out  2  registered classification.
- busy  out  1  high in every state except IDLE.
- abort  in  1  synchronous abort back to IDLE.
- timeout_err  out  1  sticky error flag.
- err_clear  in  1  clears timeout_err and leaves ERROR.

Behaviour:
- Reset (rst=0, async): state=IDLE, layer_idx=0, all counters=0, layer_start=0, result_valid=0, result_class=0, timeout_err=0, busy=0. feat_ready=1 from the first cycle after reset release.
- IDLE:
  - feat_ready=1.
  - feat_valid&&feat_ready at an edge → START, layer_idx=0.
- START:
  - layer_start[layer_idx]=1 for exactly this one cycle; timeout counter cleared.
  - Always → RUN next cycle.
- RUN:
  - Timeout counter increments each cycle.
  - layer_done[layer_idx]=1: if layer_idx<NUM_LAYERS-1, layer_idx++ and → START; otherwise → FINAL with latency counter=0.
  - layer_done bits other than layer_idx are ignored.
  - layer_done asserted in the START cycle is ignored; sampling begins in RUN.
  - Counter reaches TIMEOUT_CYCLES-1 with no done → ERROR, timeout_err=1.
  - Done and timeout in the same cycle: done wins.
  - Minimum per-layer cost: 2 cycles (START + RUN).
- FINAL:
  - Counts FINAL_LAT cycles.
  - On the edge where the count equals FINAL_LAT-1: result_class<=class_in, result_valid<=1, → RESULT.
- RESULT:
  - result_valid=1; result_class stays stable until the handshake.
  - result_valid&&result_ready at an edge → IDLE, result_valid=0; feat_ready=1 the next cycle.
  - A new frame is never accepted in the handshake cycle.
- ERROR:
  - busy=1, feat_ready=0, no start pulses.
  - err_clear → IDLE, timeout_err=0.
- abort:
  - From START, RUN, FINAL or RESULT → IDLE next edge; counters and layer_idx cleared; result_valid=0.
  - Abort has priority over done, timeout and result handshake.
  - Abort in IDLE or ERROR: no effect; it does not clear timeout_err.
- End-to-end latency from frame acceptance to result_valid = Σ(layer run cycles) + NUM_LAYERS + FINAL_LAT cycles.
- rst asserted mid-operation: immediate return to reset values; any in-flight layer is abandoned.

Decomposition:
- nn_parameters package:
  - state enum seq_state_t {IDLE, START, RUN, FINAL, RESULT, ERROR}.
  - NUM_LAYERS, FINAL_LAT, TIMEOUT_CYCLES, CNT_W.
  - class_t (logic [1:0]).
- Sub-module seq_timeout_counter: load/clear, enable, terminal-count flag; reused for both the timeout and FINAL_LAT counts.

Test Plan:
- Nominal frame:
  - Stimulus: feat_valid at t0; each layer returns done 5 cycles after its start; class_in=2; result_ready=1.
  - Response: layer_start pulses in order 0..3, one cycle each; result_valid high with result_class=2 at cycle 4*(1+5)+FINAL_LAT after acceptance; feat_ready=1 the next cycle.
- Backpressure:
  - Stimulus: result_ready=0 for 20 cycles; class_in changes to 1 meanwhile.
  - Response: result_class stays at the latched 2; feat_valid is not accepted until the handshake.
- Wrong and early done:
  - Stimulus: layer_done[2] while layer 0 runs; layer_done[0] in the START cycle.
  - Response: both ignored; layer 1 starts only after a valid RUN-cycle done[0].
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; layer 1 never signals done.
  - Response: timeout_err=1 after 100 RUN cycles; feat_ready=0; err_clear returns to IDLE with feat_ready=1.
- Abort race:
  - Stimulus: abort and layer_done[3] in the same cycle.
  - Response: state is IDLE; no result_valid.
- Async reset mid-RUN:
  - Stimulus: rst=0 for 3 cycles mid-RUN.
  - Response: all outputs at reset values immediately; normal frame completes afterward.

Source files
------------

// File: rtl/nn_layer_sequencer_pkg.sv
// Shared types and default sizing for the speech-network layer sequencer.
package nn_parameters;

    localparam int NUM_LAYERS     = 4;
    localparam int FINAL_LAT      = 2;
    localparam int TIMEOUT_CYCLES = 65535;
    localparam int CNT_W          = 16;

    typedef logic [1:0] class_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        FINAL,
        RESULT,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/nn_layer_sequencer_timeout_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; shared by the
// per-layer timeout and the final-stage latency wait.
module seq_timeout_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_tc_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_tc_val);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer: accepts a feature frame, starts each dense layer in turn,
// waits out the argmax latency and hands the class over a valid/ready port.
//   state  | meaning
//   IDLE   | waiting for a feature frame
//   START  | one-cycle start pulse for layer r_layer_idx
//   RUN    | layer running, watching its done and the timeout
//   FINAL  | waiting for the registered argmax to settle
//   RESULT | result_valid held until the consumer takes it
//   ERROR  | a layer hung; held until err_clear
import nn_parameters::*;

module nn_layer_sequencer #(
    parameter int NUM_LAYERS     = nn_parameters::NUM_LAYERS,
    parameter int FINAL_LAT      = nn_parameters::FINAL_LAT,
    parameter int TIMEOUT_CYCLES = nn_parameters::TIMEOUT_CYCLES,
    parameter int CNT_W          = nn_parameters::CNT_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_feat_valid,
    output logic                  o_feat_ready,
    output logic [NUM_LAYERS-1:0] o_layer_start,
    input  logic [NUM_LAYERS-1:0] i_layer_done,
    input  class_t                i_class_in,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output class_t                o_result_class,
    output logic                  o_busy,
    input  logic                  i_abort,
    output logic                  o_timeout_err,
    input  logic                  i_err_clear
);

    localparam int LIDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);

    seq_state_t        r_state, w_state_next;
    logic [LIDX_W-1:0] r_layer_idx, w_layer_idx_next;
    logic              r_result_valid, w_result_valid_next;
    class_t            r_result_class, w_result_class_next;
    logic              r_timeout_err, w_timeout_err_next;
    logic              w_cnt_clr, w_cnt_en, w_cnt_tc;
    logic [CNT_W-1:0]  w_tc_val;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_layer_idx    <= '0;
            r_result_valid <= 1'b0;
            r_result_class <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_layer_idx    <= w_layer_idx_next;
            r_result_valid <= w_result_valid_next;
            r_result_class <= w_result_class_next;
            r_timeout_err  <= w_timeout_err_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_layer_idx_next    = r_layer_idx;
        w_result_valid_next = r_result_valid;
        w_result_class_next = r_result_class;
        w_timeout_err_next  = r_timeout_err;
        // Abort outranks done, timeout and the result handshake.
        if (i_abort && (r_state inside {START, RUN, FINAL, RESULT})) begin
            w_state_next        = IDLE;
            w_layer_idx_next    = '0;
            w_result_valid_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_feat_valid) begin
                        w_state_next     = START;
                        w_layer_idx_next = '0;
                    end
                end
                START: w_state_next = RUN;
                RUN: begin
                    if (i_layer_done[r_layer_idx]) begin
                        if (r_layer_idx == LAST_IDX) begin
                            w_state_next = FINAL;
                        end else begin
                            w_layer_idx_next = r_layer_idx + 1'b1;
                            w_state_next     = START;
                        end
                    end else if (w_cnt_tc) begin
                        w_state_next       = ERROR;
                        w_timeout_err_next = 1'b1;
                    end
                end
                FINAL: begin
                    if (w_cnt_tc) begin
                        w_state_next        = RESULT;
                        w_result_valid_next = 1'b1;
                        w_result_class_next = i_class_in;
                    end
                end
                RESULT: begin
                    if (i_result_ready) begin
                        w_state_next        = IDLE;
                        w_result_valid_next = 1'b0;
                        w_layer_idx_next    = '0;
                    end
                end
                ERROR: begin
                    if (i_err_clear) begin
                        w_state_next       = IDLE;
                        w_timeout_err_next = 1'b0;
                        w_layer_idx_next   = '0;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Counter restarts at zero on every state change so RUN and FINAL both begin at 0.
    assign w_cnt_en  = (r_state == RUN) || (r_state == FINAL);
    assign w_cnt_clr = !w_cnt_en || (w_state_next != r_state);
    assign w_tc_val  = (r_state == FINAL) ? CNT_W'(FINAL_LAT - 1) : CNT_W'(TIMEOUT_CYCLES - 1);

    seq_timeout_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_cnt_clr),
        .i_en     (w_cnt_en),
        .i_tc_val (w_tc_val),
        .o_tc     (w_cnt_tc)
    );

    always_comb begin
        o_layer_start = '0;
        if (r_state == START) begin
            o_layer_start[r_layer_idx] = 1'b1;
        end
    end

    assign o_feat_ready   = (r_state == IDLE);
    assign o_busy         = (r_state != IDLE);
    assign o_result_valid = r_result_valid;
    assign o_result_class = r_result_class;
    assign o_timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with a shortened layer timeout of 100 cycles.
module tb_nn_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       feat_valid = 1'b0;
    logic       feat_ready;
    logic [3:0] layer_start;
    logic [3:0] layer_done = '0;
    logic [1:0] class_in = '0;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic [1:0] result_class;
    logic       busy;
    logic       abort = 1'b0;
    logic       timeout_err;
    logic       err_clear = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_cnt = 0;
    int lat;
    int n;
    bit bad;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.NUM_LAYERS(4), .FINAL_LAT(2), .TIMEOUT_CYCLES(100), .CNT_W(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_feat_valid   (feat_valid),
        .o_feat_ready   (feat_ready),
        .o_layer_start  (layer_start),
        .i_layer_done   (layer_done),
        .i_class_in     (class_in),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready),
        .o_result_class (result_class),
        .o_busy         (busy),
        .i_abort        (abort),
        .o_timeout_err  (timeout_err),
        .i_err_clear    (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // Accept a frame, run every layer for run_n RUN cycles, return edges until result_valid.
    task automatic run_frame(input int run_n, output int lat_o);
        int g;
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        edge_cnt = 0;
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("start%0d", l), layer_start, 32'(1 << l));
            tick();
            chk($sformatf("pulse_len%0d", l), layer_start, 0);
            repeat (run_n - 1) tick();
            layer_done = 4'(1 << l);
            tick();
            layer_done = '0;
        end
        g = 0;
        while (!result_valid && g < 20) begin
            tick();
            g++;
        end
        lat_o = edge_cnt;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_start", layer_start, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_class", result_class, 0);
        chk("rst_terr", timeout_err, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", feat_ready, 1);

        // nominal frame
        class_in = 2'd2;
        result_ready = 1'b1;
        run_frame(5, lat);
        chk("nom_latency", lat, 26);
        chk("nom_class", result_class, 2);
        chk("nom_hs_no_ready", feat_ready, 0);
        tick();
        chk("nom_valid_drop", result_valid, 0);
        chk("nom_ready_back", feat_ready, 1);
        chk("nom_busy", busy, 0);

        // backpressure
        result_ready = 1'b0;
        run_frame(5, lat);
        chk("bp_latency", lat, 26);
        class_in = 2'd1;
        feat_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (!result_valid || result_class != 2'd2 || feat_ready || layer_start != 0) bad = 1;
        end
        chk("bp_hold", bad, 0);
        result_ready = 1'b1;
        tick();
        chk("bp_hs_valid", result_valid, 0);
        chk("bp_hs_nostart", layer_start, 0);
        tick();
        chk("bp_accept_after", layer_start, 1);
        feat_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_start", busy, 0);

        // wrong and early done
        class_in = 2'd3;
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        edge_cnt = 0;
        layer_done = 4'b0001;
        tick();
        chk("early_done", layer_start, 0);
        layer_done = 4'b0100;
        tick();
        chk("wrong_done", layer_start, 0);
        layer_done = 4'b0000;
        tick();
        layer_done = 4'b0001;
        tick();
        layer_done = 4'b0000;
        chk("l1_start", layer_start, 2);
        for (int l = 1; l < 4; l++) begin
            tick();
            layer_done = 4'(1 << l);
            tick();
            layer_done = '0;
        end
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wd_latency", edge_cnt, 12);
        chk("wd_class", result_class, 3);
        tick();

        // done wins over timeout on the last permitted RUN cycle
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        repeat (100) tick();
        layer_done = 4'b0001;
        tick();
        layer_done = '0;
        chk("done_wins_err", timeout_err, 0);
        chk("done_wins_start", layer_start, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // timeout on layer 1
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        tick();
        layer_done = 4'b0001;
        tick();
        layer_done = '0;
        chk("to_l1_start", layer_start, 2);
        n = 0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
        end
        chk("to_edges", n, 101);
        chk("to_feat_ready", feat_ready, 0);
        chk("to_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("to_abort_sticky", timeout_err, 1);
        chk("to_abort_busy", busy, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clr_terr", timeout_err, 0);
        chk("clr_ready", feat_ready, 1);

        // abort races the last layer's done
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        for (int l = 0; l < 3; l++) begin
            tick();
            layer_done = 4'(1 << l);
            tick();
            layer_done = '0;
        end
        chk("race_l3_start", layer_start, 8);
        tick();
        layer_done = 4'b1000;
        abort = 1'b1;
        tick();
        layer_done = '0;
        abort = 1'b0;
        chk("race_idle", busy, 0);
        bad = 0;
        repeat (4) begin
            tick();
            if (result_valid) bad = 1;
        end
        chk("race_no_result", bad, 0);

        // async reset mid-RUN
        feat_valid = 1'b1;
        tick();
        feat_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", feat_ready, 1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        class_in = 2'd1;
        run_frame(2, lat);
        chk("arst_latency", lat, 14);
        chk("arst_class", result_class, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
